// File: rtl/rom_dl_scheduler.sv
// ROM download scheduler: buffers ioctl byte writes, dispatches them to SDRAM
// ports 1/2 (toggle handshake) or the PROM bus, and derives rom_loaded/core_reset.
module rom_dl_scheduler #(
  parameter logic [24:0] SP_BASE    = 25'h30000,
  parameter logic [24:0] PROM_BASE  = 25'hA0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          RST_CNT_W  = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic        prom_wr,
  input  logic        user_reset,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded,
  output logic        core_reset
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  // ---------------- capture FIFO ----------------
  dl_entry_t   mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        wr_prev_q, downl_prev_q;
  logic        fifo_empty, fifo_full, wr_edge, dl_start, push, pop;
  state_t      state_q, state_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_edge    = ioctl_wr & ~wr_prev_q & ioctl_downl;
  assign dl_start   = ioctl_downl & ~downl_prev_q;
  // A full FIFO drops the write even if a pop happens in the same cycle.
  assign push       = wr_edge & ~fifo_full;
  assign pop        = (state_q == IDLE) & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{addr: ioctl_addr, data: ioctl_dout};
  end

  // ---------------- dispatcher ----------------
  dl_entry_t   hold_q, hold_d;
  logic        p2_act_q, p2_act_d;
  logic        port1_req_q, port1_req_d, port2_req_q, port2_req_d;
  logic [22:0] port1_a_q, port1_a_d, port2_a_q, port2_a_d;
  logic [1:0]  port1_ds_q, port1_ds_d, port2_ds_q, port2_ds_d;
  logic [15:0] port1_d_q, port1_d_d, port2_d_q, port2_d_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;
  logic        prom_wr_q, prom_wr_d;
  logic [23:0] sp_off;
  logic [11:0] prom_off;

  // Only the low bits of each offset are consumed, so subtract in that width.
  assign sp_off   = hold_q.addr[23:0] - SP_BASE[23:0];
  assign prom_off = hold_q.addr[11:0] - PROM_BASE[11:0];

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    p2_act_d    = p2_act_q;
    port1_req_d = port1_req_q;
    port1_a_d   = port1_a_q;
    port1_ds_d  = port1_ds_q;
    port1_d_d   = port1_d_q;
    port2_req_d = port2_req_q;
    port2_a_d   = port2_a_q;
    port2_ds_d  = port2_ds_q;
    port2_d_d   = port2_d_q;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    prom_wr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          hold_d  = mem_q[rd_ptr_q[AW-1:0]];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hold_q.addr >= PROM_BASE) begin
          prom_addr_d = prom_off;
          prom_data_d = hold_q.data;
          prom_wr_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          port1_a_d   = hold_q.addr[23:1];
          port1_ds_d  = {hold_q.addr[0], ~hold_q.addr[0]};
          port1_d_d   = {2{hold_q.data}};
          port1_req_d = ~port1_req_q;
          p2_act_d    = 1'b0;
          if (hold_q.addr >= SP_BASE) begin
            port2_a_d   = sp_off[23:1];
            port2_ds_d  = {sp_off[0], ~sp_off[0]};
            port2_d_d   = {2{hold_q.data}};
            port2_req_d = ~port2_req_q;
            p2_act_d    = 1'b1;
          end
          state_d = WAIT;
        end
      end
      WAIT: begin
        if ((port1_ack == port1_req_q) && (!p2_act_q || (port2_ack == port2_req_q)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- status and reset stretch ----------------
  logic                 overflow_q, overflow_d;
  logic                 rom_loaded_q, rom_loaded_d;
  logic                 core_reset_q, core_reset_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  assign busy = ~fifo_empty | (state_q != IDLE);

  always_comb begin
    overflow_d = overflow_q;
    if (dl_start) overflow_d = 1'b0;
    if (wr_edge && fifo_full) overflow_d = 1'b1;

    rom_loaded_d = rom_loaded_q;
    if (dl_start && (ioctl_index == 8'd0)) rom_loaded_d = 1'b0;
    else if (!ioctl_downl && !busy)         rom_loaded_d = 1'b1;

    if (user_reset || !rom_loaded_q) rst_cnt_d = '1;
    else if (rst_cnt_q != '0)        rst_cnt_d = rst_cnt_q - 1'b1;
    else                             rst_cnt_d = rst_cnt_q;
    // Registered from the next count so assertion shows one cycle after the cause.
    core_reset_d = (rst_cnt_d != '0);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_prev_q    <= 1'b0;
      downl_prev_q <= 1'b0;
      state_q      <= IDLE;
      hold_q       <= '0;
      p2_act_q     <= 1'b0;
      port1_req_q  <= 1'b0;
      port1_a_q    <= '0;
      port1_ds_q   <= '0;
      port1_d_q    <= '0;
      port2_req_q  <= 1'b0;
      port2_a_q    <= '0;
      port2_ds_q   <= '0;
      port2_d_q    <= '0;
      prom_addr_q  <= '0;
      prom_data_q  <= '0;
      prom_wr_q    <= 1'b0;
      overflow_q   <= 1'b0;
      rom_loaded_q <= 1'b1;
      core_reset_q <= 1'b1;
      rst_cnt_q    <= '1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_prev_q    <= ioctl_wr;
      downl_prev_q <= ioctl_downl;
      state_q      <= state_d;
      hold_q       <= hold_d;
      p2_act_q     <= p2_act_d;
      port1_req_q  <= port1_req_d;
      port1_a_q    <= port1_a_d;
      port1_ds_q   <= port1_ds_d;
      port1_d_q    <= port1_d_d;
      port2_req_q  <= port2_req_d;
      port2_a_q    <= port2_a_d;
      port2_ds_q   <= port2_ds_d;
      port2_d_q    <= port2_d_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
      prom_wr_q    <= prom_wr_d;
      overflow_q   <= overflow_d;
      rom_loaded_q <= rom_loaded_d;
      core_reset_q <= core_reset_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign port1_req  = port1_req_q;
  assign port1_a    = port1_a_q;
  assign port1_ds   = port1_ds_q;
  assign port1_d    = port1_d_q;
  assign port2_req  = port2_req_q;
  assign port2_a    = port2_a_q;
  assign port2_ds   = port2_ds_q;
  assign port2_d    = port2_d_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign prom_wr    = prom_wr_q;
  assign overflow   = overflow_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_rom_dl_scheduler.sv
// Scoreboard bench for rom_dl_scheduler: expected port/PROM writes are queued
// when a byte is written and compared as each request toggle or strobe appears.
module tb_rom_dl_scheduler;
  localparam logic [24:0] SP_BASE   = 25'h30000;
  localparam logic [24:0] PROM_BASE = 25'hA0000;

  logic clk_sys = 1'b0, reset = 1'b1;
  logic ioctl_downl = 1'b0, ioctl_wr = 1'b0, user_reset = 1'b0;
  logic [7:0] ioctl_index = 8'd1, ioctl_dout = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic port1_req, port2_req, port1_ack = 1'b0, port2_ack = 1'b0;
  logic [22:0] port1_a, port2_a;
  logic [1:0] port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [11:0] prom_addr;
  logic [7:0] prom_data;
  logic prom_wr, busy, overflow, rom_loaded, core_reset;

  rom_dl_scheduler dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
    .port1_d(port1_d), .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d), .prom_addr(prom_addr), .prom_data(prom_data),
    .prom_wr(prom_wr), .user_reset(user_reset), .busy(busy), .overflow(overflow),
    .rom_loaded(rom_loaded), .core_reset(core_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, errors = 0, cyc = 0, wr_cyc = 0;
  int p1_tog = 0, p2_tog = 0, p1_tog_cyc = 0, p2_tog_cyc = 0, prom_hi = 0;
  int p1_dly = 3, p2_dly = 3, p1_cnt = 0, p2_cnt = 0;
  bit ack_hold = 0;
  logic p1_prev = 1'b0, p2_prev = 1'b0;
  logic [40:0] exp1[$], exp2[$], e41;
  logic [19:0] expp[$], e20;

  always @(posedge clk_sys) cyc++;

  // SDRAM ack model: echo req after a programmable number of cycles.
  always @(negedge clk_sys) begin
    if (reset) begin
      port1_ack = 1'b0; port2_ack = 1'b0; p1_cnt = 0; p2_cnt = 0;
    end else if (!ack_hold) begin
      if (port1_req !== port1_ack) begin
        p1_cnt++;
        if (p1_cnt >= p1_dly) begin port1_ack = port1_req; p1_cnt = 0; end
      end
      if (port2_req !== port2_ack) begin
        p2_cnt++;
        if (p2_cnt >= p2_dly) begin port2_ack = port2_req; p2_cnt = 0; end
      end
    end
  end

  // Output monitor: every toggle/strobe pops and checks one expected entry.
  always @(negedge clk_sys) begin
    if (reset) begin
      p1_prev = 1'b0; p2_prev = 1'b0;
    end else begin
      if (port1_req !== p1_prev) begin
        p1_prev = port1_req; p1_tog++; p1_tog_cyc = cyc; checks++;
        if (exp1.size() == 0) begin
          errors++; $display("FAIL p1_unexpected: got a=%h ds=%b d=%h, wanted no toggle", port1_a, port1_ds, port1_d);
        end else begin
          e41 = exp1.pop_front();
          if ({port1_a, port1_ds, port1_d} !== e41) begin
            errors++; $display("FAIL p1_fields: got %h, wanted %h", {port1_a, port1_ds, port1_d}, e41);
          end
        end
      end
      if (port2_req !== p2_prev) begin
        p2_prev = port2_req; p2_tog++; p2_tog_cyc = cyc; checks++;
        if (exp2.size() == 0) begin
          errors++; $display("FAIL p2_unexpected: got a=%h ds=%b d=%h, wanted no toggle", port2_a, port2_ds, port2_d);
        end else begin
          e41 = exp2.pop_front();
          if ({port2_a, port2_ds, port2_d} !== e41) begin
            errors++; $display("FAIL p2_fields: got %h, wanted %h", {port2_a, port2_ds, port2_d}, e41);
          end
        end
      end
      if (prom_wr === 1'b1) begin
        prom_hi++; checks++;
        if (expp.size() == 0) begin
          errors++; $display("FAIL prom_unexpected: got addr=%h data=%h, wanted no strobe", prom_addr, prom_data);
        end else begin
          e20 = expp.pop_front();
          if ({prom_addr, prom_data} !== e20) begin
            errors++; $display("FAIL prom_fields: got %h, wanted %h", {prom_addr, prom_data}, e20);
          end
        end
      end
    end
  end

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input bit drop);
    logic [24:0] o;
    if (!drop) begin
      if (a >= PROM_BASE) begin
        o = a - PROM_BASE; expp.push_back({o[11:0], d});
      end else begin
        exp1.push_back({a[23:1], a[0], ~a[0], d, d});
        if (a >= SP_BASE) begin
          o = a - SP_BASE; exp2.push_back({o[23:1], o[0], ~o[0], d, d});
        end
      end
    end
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1; wr_cyc = cyc;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_busy_low(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_sys);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({port1_req, port2_req, port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d} !== '0) begin
      errors++; $display("FAIL reset_ports: got nonzero port outputs, wanted 0");
    end
    checks++;
    if ({prom_wr, prom_addr, prom_data} !== '0) begin
      errors++; $display("FAIL reset_prom: got %h, wanted 0", {prom_wr, prom_addr, prom_data});
    end
    checks++;
    if ({busy, overflow, rom_loaded, core_reset} !== 4'b0011) begin
      errors++; $display("FAIL reset_status: got %b, wanted 0011", {busy, overflow, rom_loaded, core_reset});
    end
    reset = 1'b0;
    ioctl_index = 8'd1; ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({busy, rom_loaded, core_reset} !== 3'b011) begin
      errors++; $display("FAIL post_reset: got %b, wanted 011", {busy, rom_loaded, core_reset});
    end
  endtask

  task automatic test_single();
    int t1, t2; bit ok;
    p1_dly = 3; p2_dly = 3; t1 = p1_tog; t2 = p2_tog;
    write_byte(25'h00011, 8'hA5, 0);
    for (int i = 0; i < 10 && p1_tog == t1; i++) @(negedge clk_sys);
    checks++;
    if (p1_tog_cyc - wr_cyc != 3) begin
      errors++; $display("FAIL single_latency: got %0d cycles, wanted 3", p1_tog_cyc - wr_cyc);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait: got %b, wanted 1", busy); end
    wait_busy_low(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_busy_drop: got busy stuck 1, wanted 0 after ack"); end
    checks++;
    if (p1_tog - t1 != 1 || p2_tog != t2) begin
      errors++; $display("FAIL single_toggles: got p1=%0d p2=%0d, wanted 1 0", p1_tog - t1, p2_tog - t2);
    end
  endtask

  task automatic test_sprite();
    int t2; bit ok;
    p1_dly = 3; p2_dly = 8; t2 = p2_tog;
    write_byte(25'h30004, 8'h3C, 0);
    for (int i = 0; i < 10 && p2_tog == t2; i++) @(negedge clk_sys);
    checks++;
    if (p2_tog == t2 || p1_tog_cyc != p2_tog_cyc) begin
      errors++; $display("FAIL sprite_same_cycle: got p1 cyc %0d p2 cyc %0d, wanted equal", p1_tog_cyc, p2_tog_cyc);
    end
    for (int i = 0; i < 20 && port1_ack !== port1_req; i++) @(negedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1 || port2_ack === port2_req) begin
      errors++; $display("FAIL sprite_wait_p2: got busy=%b, wanted 1 while port2 unacked", busy);
    end
    wait_busy_low(20, ok);
    checks++;
    if (!ok || port2_ack !== port2_req) begin
      errors++; $display("FAIL sprite_done: got ok=%b, wanted busy low after port2 ack", ok);
    end
    p2_dly = 3;
  endtask

  task automatic test_prom();
    int t1, t2, ph;
    t1 = p1_tog; t2 = p2_tog; ph = prom_hi;
    write_byte(25'hA0305, 8'h7E, 0);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (prom_hi - ph != 1) begin errors++; $display("FAIL prom_width: got %0d cycles high, wanted 1", prom_hi - ph); end
    checks++;
    if (p1_tog != t1 || p2_tog != t2 || busy !== 1'b0) begin
      errors++; $display("FAIL prom_no_sdram: got p1=%0d p2=%0d busy=%b, wanted 0 0 0", p1_tog - t1, p2_tog - t2, busy);
    end
  endtask

  task automatic test_overflow();
    int t1; bit ok;
    t1 = p1_tog; ack_hold = 1; p1_dly = 1;
    write_byte(25'h00100, 8'h01, 0);
    repeat (4) @(negedge clk_sys);
    for (int i = 0; i < 4; i++) write_byte(25'h00102 + 25'(2 * i), 8'h10 + 8'(i), 0);
    write_byte(25'h0010A, 8'hEE, 1);
    checks++;
    if (overflow !== 1'b1 || p1_tog - t1 != 1) begin
      errors++; $display("FAIL ovf_set: got ovf=%b toggles=%0d, wanted 1 1", overflow, p1_tog - t1);
    end
    ack_hold = 0;
    wait_busy_low(80, ok);
    checks++;
    if (!ok || p1_tog - t1 != 5 || exp1.size() != 0) begin
      errors++; $display("FAIL ovf_drain: got toggles=%0d left=%0d, wanted 5 0", p1_tog - t1, exp1.size());
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, wanted 1", overflow); end
    ioctl_downl = 1'b0; @(negedge clk_sys);
    ioctl_downl = 1'b1; @(negedge clk_sys);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, wanted 0", overflow); end
  endtask

  task automatic test_download();
    int c0; bit ok, early;
    ioctl_downl = 1'b0; @(negedge clk_sys);
    ioctl_index = 8'd0; ioctl_downl = 1'b1; @(negedge clk_sys);
    checks++;
    if (rom_loaded !== 1'b0 || core_reset !== 1'b1) begin
      errors++; $display("FAIL dl_start: got loaded=%b core_reset=%b, wanted 0 1", rom_loaded, core_reset);
    end
    ack_hold = 1;
    write_byte(25'h00200, 8'h21, 0);
    write_byte(25'h00202, 8'h22, 0);
    write_byte(25'h00204, 8'h23, 0);
    ioctl_downl = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (rom_loaded !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL dl_queued: got loaded=%b busy=%b, wanted 0 1", rom_loaded, busy);
    end
    ack_hold = 0; ok = 0; early = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_sys);
      if (!busy) begin ok = 1; break; end
      if (rom_loaded) early = 1;
    end
    @(negedge clk_sys);
    checks++;
    if (!ok || early || rom_loaded !== 1'b1) begin
      errors++; $display("FAIL dl_loaded: got ok=%b early=%b loaded=%b, wanted 1 0 1", ok, early, rom_loaded);
    end
    c0 = cyc;
    for (int i = 0; i < 70000 && core_reset !== 1'b0; i++) @(negedge clk_sys);
    checks++;
    if (core_reset !== 1'b0 || cyc - c0 < 65532 || cyc - c0 > 65538) begin
      errors++; $display("FAIL dl_core_reset: got release after %0d cycles, wanted about 65536", cyc - c0);
    end
  endtask

  task automatic test_reset_mid();
    int t1;
    ioctl_index = 8'd1; ioctl_downl = 1'b1; @(negedge clk_sys);
    ack_hold = 1;
    write_byte(25'h00300, 8'h31, 0);
    write_byte(25'h00302, 8'h32, 0);
    write_byte(25'h00304, 8'h33, 0);
    repeat (2) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1 || port1_req === port1_ack) begin
      errors++; $display("FAIL mid_pre: got busy=%b, wanted 1 with ack outstanding", busy);
    end
    reset = 1'b1; #1;
    checks++;
    if ({port1_req, port2_req, port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d,
         prom_wr, prom_addr, prom_data} !== '0) begin
      errors++; $display("FAIL mid_ports: got req1=%b a1=%h, wanted all 0", port1_req, port1_a);
    end
    checks++;
    if ({busy, overflow, rom_loaded, core_reset} !== 4'b0011) begin
      errors++; $display("FAIL mid_status: got %b, wanted 0011", {busy, overflow, rom_loaded, core_reset});
    end
    exp1.delete(); exp2.delete(); expp.delete();
    ioctl_downl = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0; ack_hold = 0; t1 = p1_tog;
    repeat (20) @(negedge clk_sys);
    checks++;
    if (p1_tog != t1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_after: got toggles=%0d busy=%b, wanted 0 0", p1_tog - t1, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sprite();
    test_prom();
    test_overflow();
    test_download();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
